// File: rtl/mcu0_intc.sv
// Interrupt controller for mcu0: edge-detected IRQ lines plus abort/error requests,
// arbitrated into a single non-nesting request/accept/service handshake with the CPU.
module mcu0_intc #(
  parameter int NSRC = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic            abort_in,
  input  logic            error_in,
  input  logic [2:0]      tick,
  input  logic            iret,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [7:0]      cfg_wdata,
  output logic [7:0]      cfg_rdata,
  output logic [2:0]      itype,
  output logic [2:0]      irq_id,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } state_t;

  localparam logic [2:0] K_EXE = 3'b000;
  localparam logic [2:0] K_ABT = 3'b010;
  localparam logic [2:0] K_IRQ = 3'b011;
  localparam logic [2:0] K_ERR = 3'b100;
  // Source bits are kept 8 wide internally; bits at or above NSRC are tied to zero.
  localparam logic [7:0] SRC_MASK = 8'((9'd1 << NSRC) - 9'd1);

  state_t     state_q, state_d;
  logic [2:0] kind_q, kind_d;
  logic [2:0] win_q, win_d;
  logic [2:0] irq_id_q, irq_id_d;
  logic       busy_q, busy_d;
  logic [7:0] en_q, en_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] prev_q, prev_d;
  logic       abt_q, abt_d;
  logic       err_q, err_d;

  logic [7:0] irq_ext;
  logic [7:0] edge_set;
  logic [7:0] pend_clr;
  logic [7:0] req_vec;
  logic [2:0] win_idx;
  logic       abt_clr;
  logic       err_clr;

  assign irq_ext  = 8'(irq_in);
  assign edge_set = irq_ext & ~prev_q & SRC_MASK;
  assign req_vec  = pend_q & en_q;

  always_comb begin
    win_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_vec[i]) win_idx = 3'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    win_d    = win_q;
    irq_id_d = irq_id_q;
    busy_d   = busy_q;
    en_d     = en_q;
    prev_d   = irq_ext & SRC_MASK;
    pend_clr = 8'h00;
    abt_clr  = 1'b0;
    err_clr  = 1'b0;

    if (cfg_we) begin
      case (cfg_addr)
        2'd0:    en_d     = cfg_wdata & SRC_MASK;
        2'd1:    pend_clr = cfg_wdata & SRC_MASK;
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (err_q) begin
          kind_d  = K_ERR;
          state_d = REQ;
        end else if (abt_q) begin
          kind_d  = K_ABT;
          state_d = REQ;
        end else if (|req_vec) begin
          kind_d  = K_IRQ;
          win_d   = win_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        // Winner and kind stay frozen until the CPU reaches an instruction boundary.
        if (tick == 3'd0) begin
          state_d = SERVICE;
          busy_d  = 1'b1;
          case (kind_q)
            K_ERR:   err_clr = 1'b1;
            K_ABT:   abt_clr = 1'b1;
            default: begin
              pend_clr[win_q] = 1'b1;
              irq_id_d        = win_q;
            end
          endcase
        end
      end
      SERVICE: begin
        if (iret) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // New set events take precedence over any clear in the same cycle.
    pend_d = (pend_q & ~pend_clr) | edge_set;
    abt_d  = (abt_q & ~abt_clr) | abort_in;
    err_d  = (err_q & ~err_clr) | error_in;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      kind_q   <= K_EXE;
      win_q    <= 3'd0;
      irq_id_q <= 3'd0;
      busy_q   <= 1'b0;
      en_q     <= 8'h00;
      pend_q   <= 8'h00;
      prev_q   <= 8'h00;
      abt_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      win_q    <= win_d;
      irq_id_q <= irq_id_d;
      busy_q   <= busy_d;
      en_q     <= en_d;
      pend_q   <= pend_d;
      prev_q   <= prev_d;
      abt_q    <= abt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    cfg_rdata = 8'h00;
    case (cfg_addr)
      2'd0:    cfg_rdata = en_q;
      2'd1:    cfg_rdata = pend_q;
      2'd2:    cfg_rdata = {3'b000, busy_q, err_q, abt_q, state_q};
      default: cfg_rdata = 8'h00;
    endcase
  end

  assign itype  = (state_q == REQ) ? kind_q : K_EXE;
  assign irq_id = irq_id_q;
  assign busy   = busy_q;

endmodule

// File: doc/mcu0_intc.md
MCU0_INTC -- requirements
Module: mcu0_intc

Interface
REQ-001 The block SHALL have parameter NSRC, default 4, number of IRQ sources (legal range 1..8).
REQ-002 The block SHALL have port clock  input  1  sole clock, all state updates on posedge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port irq_in  input  NSRC  interrupt request lines, synchronous to clock, rising-edge sensitive.
REQ-005 The block SHALL have port abort_in  input  1  abort request pulse, synchronous.
REQ-006 The block SHALL have port error_in  input  1  error request pulse, synchronous.
REQ-007 The block SHALL have port tick  input  3  CPU tick counter; 0 = CPU at instruction boundary.
REQ-008 The block SHALL have port iret  input  1  one-cycle pulse, CPU finished the current handler.
REQ-009 The block SHALL have port cfg_we  input  1  register write strobe.
REQ-010 The block SHALL have port cfg_addr  input  2  register select.
REQ-011 The block SHALL have port cfg_wdata  input  8  register write data.
REQ-012 The block SHALL have port cfg_rdata  output  8  register read data, combinational from cfg_addr.
REQ-013 The block SHALL have port itype  output  3  interrupt type to CPU: 000 EXE, 010 ABORT, 011 IRQ, 100 ERROR.
REQ-014 The block SHALL have port irq_id  output  3  index of the last accepted IRQ source.
REQ-015 The block SHALL have port busy  output  1  high while a handler is in service.

Function
REQ-016 Edge detect: the block SHALL register irq_in into prev each cycle; (irq_in & ~prev) SHALL set the matching PENDING bits.
REQ-017 abort_in=1 SHALL set abt_pend; error_in=1 SHALL set err_pend; both stay set until accepted.
REQ-018 Registers: addr0 ENABLE[NSRC-1:0] rw; addr1 PENDING read, write-1-to-clear; addr2 STATUS read-only {3'b0, busy, err_pend, abt_pend, state[1:0]}; addr3 reads 0, writes ignored; bits at or above NSRC read 0.
REQ-019 The FSM SHALL have states IDLE(00), REQ(01), SERVICE(10).
REQ-020 IDLE: itype=000; the first true of err_pend, abt_pend, |(PENDING&ENABLE) SHALL be selected, latched as the request kind, and the FSM SHALL go to REQ on the next edge.
REQ-021 Arbitration priority SHALL be ERROR > ABORT > IRQ; among IRQs, lowest index wins; the winner SHALL be frozen while in REQ.
REQ-022 REQ: itype SHALL be driven to the latched kind code.
REQ-023 In REQ, an edge with tick==0 is the accept; on accept: FSM->SERVICE, itype->000, served pend bit cleared, irq_id<=winner (IRQ kind only), busy<=1.
REQ-024 In REQ with tick!=0, itype SHALL be held unchanged with no timeout.
REQ-025 SERVICE: itype=000; iret=1 SHALL set busy<=0 and FSM->IDLE; iret outside SERVICE SHALL be ignored.
REQ-026 There SHALL be no nesting: requests arriving in REQ or SERVICE only set pending bits.
REQ-027 If an IRQ source is disabled while in REQ, the request SHALL still complete, since the winner is frozen.
REQ-028 If a set (new edge) and a clear (W1C or accept) hit the same bit in one cycle, set SHALL win.
REQ-029 Accept latency: request visible in IDLE -> itype asserted exactly 1 cycle later; itype returns to 000 on the edge after the accepting edge.

Reset
REQ-030 While reset=0, the block SHALL asynchronously force: state=IDLE, itype=000, irq_id=0, busy=0, ENABLE=0, PENDING=0, abt_pend=0, err_pend=0, prev=0.
REQ-031 Reset asserted mid-REQ or mid-SERVICE SHALL drop all pending work; no request SHALL survive reset.
REQ-032 Because prev resets to 0, a line already high when reset releases SHALL register as an edge on the first clock.

Verification
REQ-033 ENABLE=0001, pulse irq_in[0], tick held 0 -> itype=011 for one cycle, then irq_id=0, busy=1, PENDING=0; iret -> busy=0, STATUS state=00.
REQ-034 ENABLE=1111, irq_in[3] and irq_in[1] rise together -> irq_id=1 served first; after iret, irq_id=3 served.
REQ-035 Pending IRQ plus error_in and abort_in in the same cycle -> ERROR (100) accepted first, then ABORT (010), then IRQ (011), each requiring an iret.
REQ-036 itype=011 with tick=1,2,3 for 3 cycles -> itype held at 011; tick=0 -> accepted on that edge.
REQ-037 In SERVICE, W1C to PENDING bit 2 in the same cycle as a new irq_in[2] edge -> PENDING[2] reads 1.
REQ-038 Reset pulsed low while in REQ -> itype=000 and all registers 0 immediately, with no accept after release.
